// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared FSM state type and magnitude helper for the repeated-addition multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_t;

    localparam int MAG_W = 64;

    // Callers zero-extend into MAG_W bits and truncate back, so -2^(W-1) yields 2^(W-1).
    function automatic logic [MAG_W-1:0] mag(input logic [MAG_W-1:0] x, input logic is_neg);
        return is_neg ? (MAG_W'(0) - x) : x;
    endfunction

endpackage

// File: rtl/mul_repadd_dp.sv
// rtl/mul_repadd_dp.sv - operand capture, accumulate/count datapath and product register
module mul_repadd_dp #(
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0,
    parameter int SWAP_MIN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               add,
    input  logic               store,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               eqz
);
    import mul_pkg::*;

    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    assign sa  = (SIGNED != 0) && a[WIDTH-1];
    assign sb  = (SIGNED != 0) && b[WIDTH-1];
    assign ma  = WIDTH'(mag(MAG_W'(a), sa));
    assign mb  = WIDTH'(mag(MAG_W'(b), sb));
    assign eqz = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                acc <= '0;
                neg <= sa ^ sb;
                // Iterate over the smaller magnitude to bound latency by min(|a|,|b|).
                if ((SWAP_MIN != 0) && (ma < mb)) begin
                    mcand <= mb;
                    cnt   <= ma;
                end else begin
                    mcand <= ma;
                    cnt   <= mb;
                end
            end else if (add) begin
                acc <= acc + {{WIDTH{1'b0}}, mcand};
                cnt <= cnt - 1'b1;
            end
            if (store) begin
                product <= neg ? -acc : acc;
            end
        end
    end

endmodule

// File: rtl/mul_repadd_seq.sv
// rtl/mul_repadd_seq.sv - control FSM and busy/done handshake for the repeated-addition multiplier
module mul_repadd_seq #(
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0,
    parameter int SWAP_MIN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);
    import mul_pkg::*;

    state_t state;
    logic   load;
    logic   add;
    logic   store;
    logic   eqz;

    assign load  = (state == IDLE) && start && !abort;
    assign add   = (state == RUN) && !abort && !eqz;
    assign store = (state == FINISH) && !abort;

    mul_repadd_dp #(
        .WIDTH    (WIDTH),
        .SIGNED   (SIGNED),
        .SWAP_MIN (SWAP_MIN)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .add     (add),
        .store   (store),
        .a       (a),
        .b       (b),
        .product (product),
        .eqz     (eqz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (eqz) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= !abort;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_repadd_seq.md
# mul_repadd_seq

Parametrised sequential multiplier that computes `a*b` by repeated addition. It adds a control FSM, a datapath, an asynchronous reset, a busy/done handshake, an abort input, and optional signed operation and operand swapping. The block is the next generation of the five-state repeated-addition multiplier control path and replaces the hand-wired controller plus datapath pair. It sits on the arithmetic side of the design and is driven by a single requester through a pulse-start handshake.

## Interface
- `WIDTH`, 8: operand width in bits; minimum 2.
- `SIGNED`, 0: 1 means operands and product are two's complement; 0 means unsigned.
- `SWAP_MIN`, 1: 1 means the iteration count is the smaller operand magnitude; 0 means the count is always `|b|`.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `abort` in 1: synchronous cancel of the operation in progress.
- `a` in WIDTH: multiplicand operand; sampled on the accepting edge only.
- `b` in WIDTH: multiplier operand; sampled on the accepting edge only.
- `product` out 2*WIDTH: result register; holds its value until the next completion or reset.
- `busy` out 1: high in RUN and FINISH.
- `done` out 1: single-cycle pulse when `product` is updated.

## Operation
- FSM states, held in the package enum: IDLE, RUN, FINISH.
- IDLE, with `start`=1 at an edge:
  - Capture magnitudes `ma`=|a| and `mb`=|b|. With SIGNED=0 these are the raw values.
  - Set `neg` = sign(a) XOR sign(b).
  - With SWAP_MIN=1: `mcand`=max(ma,mb) and `cnt`=min(ma,mb). Otherwise `mcand`=ma and `cnt`=mb.
  - Clear `acc`, then go to RUN.
- RUN, each edge:
  - `cnt`==0: go to FINISH.
  - Otherwise: `acc` <= `acc` + `mcand` and `cnt` <= `cnt` - 1.
- FINISH, one edge:
  - `product` <= `neg` ? -`acc` : `acc`.
  - `done` <= 1, then go to IDLE.
- Width rules:
  - `mcand` and `cnt` are WIDTH-bit unsigned; |-2^(WIDTH-1)| fits.
  - `acc` is 2*WIDTH-bit unsigned. No overflow is possible, including (-2^(W-1))² = 2^(2W-2).
  - `-acc` is the 2*WIDTH-bit two's complement.
- `abort`:
  - `abort`=1 in RUN or FINISH: go to IDLE on that edge. `done` stays 0 and `product` is unchanged.
  - Ignored in IDLE, and takes priority over `start` there. `abort` and `start` together in IDLE means no acceptance.
- `start` while busy is ignored and not queued.

## Timing
- Reset values: state=IDLE, `product`=0, `busy`=0, `done`=0, `acc`=0, `cnt`=0, `mcand`=0, `neg`=0.
- `rst` mid-operation drops to these values immediately; no `done` is produced.
- Latency: let the accepting edge be edge 0 and N be the final `cnt` value.
  - Edges 1..N perform the additions.
  - Edge N+1 enters FINISH.
  - Edge N+2 registers `product` and raises `done` for exactly one cycle.
  - N=0 therefore gives `done` after 2 edges.
- `busy` is high from edge 0 through edge N+2, where it falls together with the rise of `done`.
- Back-to-back operation: `start` high in the `done` cycle is accepted, because state is already IDLE. The throughput gap is zero idle cycles.
- `done`, `busy` and `product` are registered outputs with no combinational path from inputs.

## Structure
- Package `mul_pkg`:
  - FSM state typedef (IDLE=2'b00, RUN=2'b01, FINISH=2'b10); the unused encoding returns to IDLE.
  - The magnitude/abs helper function.
- Sub-module `mul_repadd_dp`, the datapath:
  - Owns `acc`, `mcand`, `cnt`, `neg`, the swap/abs logic and the final negation.
  - Takes load, add/decrement and store strobes from the top-level FSM.
  - Returns `eqz` (`cnt`==0).
- Top `mul_repadd_seq` contains the FSM and handshake outputs only.

## Test plan
- WIDTH=8, unsigned, SWAP_MIN=1: a=200, b=5 -> `done` at edge 7, `product`=1000. Same operands with SWAP_MIN=0 -> `done` at edge 7; a=5, b=200 -> `done` at edge 202, `product`=1000.
- Zero operands: a=0, b=0 -> `done` at edge 2, `product`=0. Then a=255, b=255 -> `product`=65025 at edge 257.
- SIGNED=1: a=0x80, b=0x80 -> `product`=0x4000. a=-3, b=7 -> `product`=0xFFEB. a=0, b=-1 -> `product`=0.
- Handshake:
  - `start` pulsed mid-RUN is ignored; `product` matches the first operands.
  - `start` held in the `done` cycle with new operands -> second result follows with zero idle cycles.
- `abort` asserted 3 edges into a 10-iteration job -> IDLE next edge, no `done` pulse, `product` keeps its prior value.
- `rst` asserted asynchronously mid-RUN -> all outputs 0 immediately. The following `start` with a=6, b=7 -> `product`=42.
